// File: rtl/fetch_fifo.sv
// fetch_fifo: buffers 64-bit fetch groups (two 32-bit instruction slots each)
// between the instruction fetch stage and decode. Each entry carries a per-slot
// valid mask derived at push time from the fetch PC alignment, the branch
// prediction and any fetch fault. Downstream consumes a whole entry at a time.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,

  input  logic        fetch_valid_i,
  input  logic [63:0] fetch_instr_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [1:0]  fetch_pred_branch_i,
  input  logic        fetch_fault_fetch_i,
  input  logic        fetch_fault_page_i,
  output logic        fetch_accept_o,

  output logic        out0_valid_o,
  output logic [31:0] out0_instr_o,
  output logic [31:0] out0_pc_o,
  output logic        out0_pred_taken_o,
  output logic        out0_fault_fetch_o,
  output logic        out0_fault_page_o,

  output logic        out1_valid_o,
  output logic [31:0] out1_instr_o,
  output logic [31:0] out1_pc_o,
  output logic        out1_pred_taken_o,
  output logic        out1_fault_fetch_o,
  output logic        out1_fault_page_o,

  input  logic        out_accept_i
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Pointers wrap naturally because DEPTH is a power of two.
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Per-entry slot valid masks (cleared by reset) and payload (no reset).
  logic [DEPTH-1:0] v0_mem;
  logic [DEPTH-1:0] v1_mem;
  logic [DEPTH-1:0] fault_fetch_mem;
  logic [DEPTH-1:0] fault_page_mem;
  logic [31:0]      instr0_mem [DEPTH];
  logic [31:0]      instr1_mem [DEPTH];
  logic [31:0]      pc0_mem    [DEPTH];
  logic [1:0]       pred_mem   [DEPTH];

  // Write-side entry formatting.
  logic        is_fault;
  logic        slot0_ok;
  logic        slot1_ok;
  logic        wr_v0;
  logic        wr_v1;
  logic [31:0] wr_instr0;
  logic [31:0] wr_pc0;

  assign full           = (count == FULL_CNT);
  assign empty          = (count == '0);
  assign fetch_accept_o = !full;
  assign push           = fetch_valid_i && !full && !flush_i;
  assign pop            = (out0_valid_o || out1_valid_o) && out_accept_i && !flush_i;

  // Derive the slot mask and stored slot0 fields of the incoming fetch group.
  // A fault collapses the group to a single slot0 carrier at the word-aligned
  // faulting PC with a zero instruction, so decode can raise the exception.
  always_comb begin
    is_fault  = fetch_fault_fetch_i || fetch_fault_page_i;
    slot0_ok  = !fetch_pc_i[2];
    slot1_ok  = !(slot0_ok && fetch_pred_branch_i[0]);
    wr_v0     = slot0_ok;
    wr_v1     = slot1_ok;
    wr_instr0 = fetch_instr_i[31:0];
    wr_pc0    = {fetch_pc_i[31:3], 3'b000};
    if (is_fault) begin
      wr_v0     = 1'b1;
      wr_v1     = 1'b0;
      wr_instr0 = 32'h0;
      wr_pc0    = {fetch_pc_i[31:2], 2'b00};
    end
  end

  // Pointer and occupancy tracking; flush empties the queue at the next edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot valid masks; cleared asynchronously so no stale entry survives reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v0_mem <= '0;
      v1_mem <= '0;
    end else if (push) begin
      v0_mem[wr_ptr] <= wr_v0;
      v1_mem[wr_ptr] <= wr_v1;
    end
  end

  // Entry payload storage; contents are only observed through the valid masks.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr0_mem[wr_ptr]      <= wr_instr0;
      instr1_mem[wr_ptr]      <= fetch_instr_i[63:32];
      pc0_mem[wr_ptr]         <= wr_pc0;
      pred_mem[wr_ptr]        <= fetch_pred_branch_i;
      fault_fetch_mem[wr_ptr] <= fetch_fault_fetch_i;
      fault_page_mem[wr_ptr]  <= fetch_fault_page_i;
    end
  end

  // Present the head entry; everything reads as zero while the queue is empty.
  always_comb begin
    out0_valid_o       = 1'b0;
    out0_instr_o       = 32'h0;
    out0_pc_o          = 32'h0;
    out0_pred_taken_o  = 1'b0;
    out0_fault_fetch_o = 1'b0;
    out0_fault_page_o  = 1'b0;
    out1_valid_o       = 1'b0;
    out1_instr_o       = 32'h0;
    out1_pc_o          = 32'h0;
    out1_pred_taken_o  = 1'b0;
    out1_fault_fetch_o = 1'b0;
    out1_fault_page_o  = 1'b0;
    if (!empty) begin
      out0_valid_o       = v0_mem[rd_ptr];
      out0_instr_o       = instr0_mem[rd_ptr];
      out0_pc_o          = pc0_mem[rd_ptr];
      out0_pred_taken_o  = pred_mem[rd_ptr][0] && v0_mem[rd_ptr];
      out0_fault_fetch_o = fault_fetch_mem[rd_ptr] && v0_mem[rd_ptr];
      out0_fault_page_o  = fault_page_mem[rd_ptr] && v0_mem[rd_ptr];
      out1_valid_o       = v1_mem[rd_ptr];
      out1_instr_o       = instr1_mem[rd_ptr];
      out1_pc_o          = {pc0_mem[rd_ptr][31:3], 3'b100};
      out1_pred_taken_o  = pred_mem[rd_ptr][1] && v1_mem[rd_ptr];
      // A faulting entry never has slot1 valid, so its flags stay on slot0.
      out1_fault_fetch_o = fault_fetch_mem[rd_ptr] && v1_mem[rd_ptr];
      out1_fault_page_o  = fault_page_mem[rd_ptr] && v1_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_fifo.sv
// tb_fetch_fifo: directed scoreboard bench for fetch_fifo (DEPTH = 4).
module tb_fetch_fifo;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic        fetch_valid_i;
  logic [63:0] fetch_instr_i;
  logic [31:0] fetch_pc_i;
  logic [1:0]  fetch_pred_branch_i;
  logic        fetch_fault_fetch_i;
  logic        fetch_fault_page_i;
  logic        fetch_accept_o;
  logic        out0_valid_o, out0_pred_taken_o, out0_fault_fetch_o, out0_fault_page_o;
  logic [31:0] out0_instr_o, out0_pc_o;
  logic        out1_valid_o, out1_pred_taken_o, out1_fault_fetch_o, out1_fault_page_o;
  logic [31:0] out1_instr_o, out1_pc_o;
  logic        out_accept_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        pt0;
    logic        pt1;
    logic        ff;
    logic        fp;
  } exp_t;

  exp_t sb_q[$];

  fetch_fifo #(.DEPTH(4)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_instr_i       (fetch_instr_i),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_pred_branch_i (fetch_pred_branch_i),
    .fetch_fault_fetch_i (fetch_fault_fetch_i),
    .fetch_fault_page_i  (fetch_fault_page_i),
    .fetch_accept_o      (fetch_accept_o),
    .out0_valid_o        (out0_valid_o),
    .out0_instr_o        (out0_instr_o),
    .out0_pc_o           (out0_pc_o),
    .out0_pred_taken_o   (out0_pred_taken_o),
    .out0_fault_fetch_o  (out0_fault_fetch_o),
    .out0_fault_page_o   (out0_fault_page_o),
    .out1_valid_o        (out1_valid_o),
    .out1_instr_o        (out1_instr_o),
    .out1_pc_o           (out1_pc_o),
    .out1_pred_taken_o   (out1_pred_taken_o),
    .out1_fault_fetch_o  (out1_fault_fetch_o),
    .out1_fault_page_o   (out1_fault_page_o),
    .out_accept_i        (out_accept_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic v0, input logic v1, input logic [31:0] i0,
                              input logic [31:0] i1, input logic [31:0] pc0, input logic [31:0] pc1,
                              input logic pt0, input logic pt1, input logic ff, input logic fp);
    exp_t e;
    e.v0 = v0; e.v1 = v1; e.i0 = i0; e.i1 = i1; e.pc0 = pc0; e.pc1 = pc1;
    e.pt0 = pt0; e.pt1 = pt1; e.ff = ff; e.fp = fp;
    return e;
  endfunction

  // Monitor: every time the DUT hands over an entry, compare against the queue head.
  always @(negedge clk_i) begin
    if (rstn_i && (out0_valid_o || out1_valid_o) && out_accept_i && !flush_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pop", 64'(out0_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("[TB] pop pc0=%08h v0=%0b v1=%0b", out0_pc_o, out0_valid_o, out1_valid_o);
        chk("out0_valid", 64'(out0_valid_o), 64'(e.v0));
        chk("out1_valid", 64'(out1_valid_o), 64'(e.v1));
        chk("out0_pred", 64'(out0_pred_taken_o), 64'(e.pt0));
        chk("out1_pred", 64'(out1_pred_taken_o), 64'(e.pt1));
        if (e.v0) begin
          chk("out0_instr", 64'(out0_instr_o), 64'(e.i0));
          chk("out0_pc", 64'(out0_pc_o), 64'(e.pc0));
          chk("out0_fault_fetch", 64'(out0_fault_fetch_o), 64'(e.ff));
          chk("out0_fault_page", 64'(out0_fault_page_o), 64'(e.fp));
        end
        if (e.v1) begin
          chk("out1_instr", 64'(out1_instr_o), 64'(e.i1));
          chk("out1_pc", 64'(out1_pc_o), 64'(e.pc1));
          chk("out1_fault_fetch", 64'(out1_fault_fetch_o), 64'h0);
          chk("out1_fault_page", 64'(out1_fault_page_o), 64'h0);
        end
      end
    end
  end

  task automatic idle();
    fetch_valid_i       = 1'b0;
    fetch_fault_fetch_i = 1'b0;
    fetch_fault_page_i  = 1'b0;
    fetch_pred_branch_i = 2'b00;
  endtask

  // Drive one fetch group for one cycle; queue the expectation if it is accepted.
  task automatic do_push(input logic [31:0] pc, input logic [63:0] instr, input logic [1:0] pred,
                         input logic ff, input logic fp, input exp_t e);
    fetch_valid_i       = 1'b1;
    fetch_pc_i          = pc;
    fetch_instr_i       = instr;
    fetch_pred_branch_i = pred;
    fetch_fault_fetch_i = ff;
    fetch_fault_page_i  = fp;
    @(negedge clk_i);
    if (fetch_accept_o) sb_q.push_back(e);
    $display("[TB] push pc=%08h accept=%0b", pc, fetch_accept_o);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; out_accept_i = 1'b0;
    fetch_instr_i = '0; fetch_pc_i = '0;
    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_out0_valid", 64'(out0_valid_o), 64'h0);
    chk("rst_out1_valid", 64'(out1_valid_o), 64'h0);
    chk("rst_accept", 64'(fetch_accept_o), 64'h1);
    chk("rst_out0_pc", 64'(out0_pc_o), 64'h0);
    chk("rst_out1_instr", 64'(out1_instr_o), 64'h0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    out_accept_i = 1'b1;

    // Basic two-slot group; not visible in the push cycle itself.
    fetch_valid_i = 1'b1; fetch_pc_i = 32'h8000_0000;
    fetch_instr_i = 64'h00000013_00100093; fetch_pred_branch_i = 2'b00;
    @(negedge clk_i);
    chk("no_bypass", 64'(out0_valid_o | out1_valid_o), 64'h0);
    sb_q.push_back(mk(1, 1, 32'h00100093, 32'h00000013, 32'h8000_0000, 32'h8000_0004, 0, 0, 0, 0));
    @(posedge clk_i); #1;
    idle();
    repeat (2) @(posedge clk_i); #1;

    // Odd-word PC and predicted-taken slot0.
    do_push(32'h8000_0004, 64'hAAAAAAAA_BBBBBBBB, 2'b00, 0, 0,
            mk(0, 1, 32'h0, 32'hAAAAAAAA, 32'h0, 32'h8000_0004, 0, 0, 0, 0));
    do_push(32'h8000_0008, 64'h22222222_11111111, 2'b01, 0, 0,
            mk(1, 0, 32'h11111111, 32'h0, 32'h8000_0008, 32'h0, 1, 0, 0, 0));
    do_push(32'h8000_0010, 64'h44444444_33333333, 2'b10, 0, 0,
            mk(1, 1, 32'h33333333, 32'h44444444, 32'h8000_0010, 32'h8000_0014, 0, 1, 0, 0));
    idle();
    repeat (3) @(posedge clk_i); #1;

    // Fill to DEPTH with the consumer stalled.
    out_accept_i = 1'b0;
    for (int i = 0; i < 4; i++)
      do_push(32'h9000_0000 + 32'(i * 8), {32'hC000_0000 + 32'(i), 32'hB000_0000 + 32'(i)}, 2'b00, 0, 0,
              mk(1, 1, 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i),
                 32'h9000_0000 + 32'(i * 8), 32'h9000_0004 + 32'(i * 8), 0, 0, 0, 0));
    fetch_pc_i = 32'h9000_0100;  // fifth group offered while full
    @(negedge clk_i);
    chk("full_accept", 64'(fetch_accept_o), 64'h0);
    chk("head_stable_a", 64'(out0_pc_o), 64'h9000_0000);
    @(posedge clk_i); #1;
    idle();
    @(negedge clk_i);
    chk("head_stable_b", 64'(out0_instr_o), 64'hB000_0000);
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;
    @(posedge clk_i); #1;
    out_accept_i = 1'b0;
    @(negedge clk_i);
    chk("accept_after_pop", 64'(fetch_accept_o), 64'h1);
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;
    repeat (5) @(posedge clk_i); #1;
    chk("drain_empty", 64'(sb_q.size()), 64'h0);

    // Flush with three buffered entries and a simultaneous push attempt.
    out_accept_i = 1'b0;
    for (int i = 0; i < 3; i++)
      do_push(32'hA000_0000 + 32'(i * 8), 64'h0, 2'b00, 0, 0,
              mk(1, 1, 32'h0, 32'h0, 32'hA000_0000 + 32'(i * 8), 32'hA000_0004 + 32'(i * 8), 0, 0, 0, 0));
    flush_i = 1'b1; fetch_valid_i = 1'b1; fetch_pc_i = 32'hA000_0100;
    @(posedge clk_i); #1;
    flush_i = 1'b0; idle();
    sb_q.delete();
    @(negedge clk_i);
    chk("flush_out0_valid", 64'(out0_valid_o), 64'h0);
    chk("flush_out1_valid", 64'(out1_valid_o), 64'h0);
    chk("flush_accept", 64'(fetch_accept_o), 64'h1);
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;

    // Faulting groups collapse onto slot0.
    do_push(32'h8000_1006, 64'hDEADBEEF_CAFEF00D, 2'b00, 0, 1,
            mk(1, 0, 32'h0, 32'h0, 32'h8000_1004, 32'h0, 0, 0, 0, 1));
    do_push(32'h8000_2000, 64'h12345678_9ABCDEF0, 2'b00, 1, 0,
            mk(1, 0, 32'h0, 32'h0, 32'h8000_2000, 32'h0, 0, 0, 1, 0));
    idle();
    repeat (3) @(posedge clk_i); #1;

    // Steady push+pop at occupancy 2 across several pointer wraps.
    out_accept_i = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 2) out_accept_i = 1'b1;
      do_push(32'h8100_0000 + 32'(i * 8), {32'h0000_0100 + 32'(i), 32'(i)}, 2'b00, 0, 0,
              mk(1, 1, 32'(i), 32'h0000_0100 + 32'(i),
                 32'h8100_0000 + 32'(i * 8), 32'h8100_0004 + 32'(i * 8), 0, 0, 0, 0));
    end
    out_accept_i = 1'b0;
    for (int i = 18; i < 20; i++)
      do_push(32'h8100_0000 + 32'(i * 8), {32'h0000_0100 + 32'(i), 32'(i)}, 2'b00, 0, 0,
              mk(1, 1, 32'(i), 32'h0000_0100 + 32'(i),
                 32'h8100_0000 + 32'(i * 8), 32'h8100_0004 + 32'(i * 8), 0, 0, 0, 0));
    idle();
    @(negedge clk_i);
    chk("occ2_full_after_two", 64'(fetch_accept_o), 64'h0);
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;
    repeat (6) @(posedge clk_i); #1;
    chk("wrap_drain_empty", 64'(sb_q.size()), 64'h0);

    // Reset in the middle of operation drops everything.
    out_accept_i = 1'b0;
    do_push(32'h8200_0000, 64'h1, 2'b00, 0, 0, mk(1, 1, 32'h1, 32'h0, 32'h8200_0000, 32'h8200_0004, 0, 0, 0, 0));
    do_push(32'h8200_0008, 64'h2, 2'b00, 0, 0, mk(1, 1, 32'h2, 32'h0, 32'h8200_0008, 32'h8200_000C, 0, 0, 0, 0));
    idle();
    rstn_i = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out0_valid_o | out1_valid_o), 64'h0);
    chk("async_rst_accept", 64'(fetch_accept_o), 64'h1);
    sb_q.delete();
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_valid", 64'(out0_valid_o | out1_valid_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_fifo.md
FETCH_FIFO -- requirements
Module: fetch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 64-bit fetch entries buffered; power of two, minimum 2.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk_i, rstn_i.
REQ-003 SHALL have ports clk_i (input, 1, clock) and rstn_i (input, 1, async active-low reset).
REQ-004 SHALL have port flush_i (input, 1): branch/exception redirect; discards all buffered entries.
REQ-005 SHALL have upstream ports: fetch_valid_i (input, 1); fetch_instr_i (input, 64); fetch_pc_i (input, 32; bits [2:0] are significant in bit 2 only); fetch_pred_branch_i (input, 2; bit0 = slot0 predicted taken, bit1 = slot1); fetch_fault_fetch_i (input, 1); fetch_fault_page_i (input, 1).
REQ-006 SHALL have port fetch_accept_o (output, 1): entry accepted this cycle when high with fetch_valid_i.
REQ-007 SHALL have per-slot outputs for n = 0,1: outn_valid_o (1); outn_instr_o (32); outn_pc_o (32); outn_pred_taken_o (1); outn_fault_fetch_o (1); outn_fault_page_o (1).
REQ-008 SHALL have port out_accept_i (input, 1): downstream consumes the whole head entry (both slots).

Function
REQ-009 SHALL compute fetch_accept_o = !full, where full means occupancy == DEPTH; it SHALL NOT depend on out_accept_i or flush_i.
REQ-010 SHALL push when fetch_valid_i && fetch_accept_o && !flush_i; the pushed entry is visible on outputs no earlier than the next cycle (no combinational bypass).
REQ-011 SHALL pop the head when (out0_valid_o || out1_valid_o) && out_accept_i && !flush_i.
REQ-012 SHALL allow push and pop in the same cycle; occupancy is unchanged and both pointers advance.
REQ-013 SHALL wrap read/write pointers modulo DEPTH; occupancy is tracked with an extra pointer bit or counter of width log2(DEPTH)+1.
REQ-014 SHALL derive slot mask at push: slot0 valid = !fetch_pc_i[2]; slot1 valid = !(slot0 valid && fetch_pred_branch_i[0]).
REQ-015 SHALL drive slot0 pc = {fetch_pc_i[31:3],3'b000} and slot1 pc = {fetch_pc_i[31:3],3'b100}; slot0 instr = fetch_instr_i[31:0] and slot1 instr = fetch_instr_i[63:32].
REQ-016 SHALL drive outn_pred_taken_o = fetch_pred_branch_i[n] of the stored entry, gated by that slot's valid.
REQ-017 SHALL, when either fault input is set at push, store the entry as: slot0 valid with both fault flags copied, slot0 instr 0, slot0 pc = {fetch_pc_i[31:2],2'b00}; slot1 invalid.
REQ-018 SHALL drive all outn_* from the head entry when non-empty; when empty, all outn_valid_o = 0 and the data outputs 0.
REQ-019 SHALL, on flush_i, reset both pointers and occupancy to 0 at the next edge; a push or pop attempted in the flush cycle is discarded; outputs are all invalid the cycle after the flush.
REQ-020 SHALL hold the head entry stable while out_accept_i is low.

Reset
REQ-021 SHALL, while rstn_i is low, clear pointers, occupancy and all stored valid masks asynchronously; all outn_valid_o = 0, data outputs 0, fetch_accept_o = 1.
REQ-022 SHALL discard in-flight contents when reset asserts mid-operation; no entry survives reset.

Verification
REQ-023 Push pc=0x8000_0000, instr=0x00000013_00100093, pred=00 -> next cycle out0 pc 0x8000_0000 instr 0x00100093, out1 pc 0x8000_0004 instr 0x00000013, both valid.
REQ-024 Push pc=0x8000_0004, pred=00 -> out0_valid_o=0, out1_valid_o=1, out1 pc 0x8000_0004; push pc=0x8000_0008, pred=01 -> out0 valid with pred_taken=1, out1_valid_o=0.
REQ-025 Hold out_accept_i=0, push 4 entries -> fetch_accept_o=0 after the 4th; pop 1 -> fetch_accept_o=1 the next cycle; entries come out in push order with no loss.
REQ-026 With 3 entries, assert flush_i plus fetch_valid_i for one cycle -> next cycle all outputs invalid, occupancy 0, fetch_accept_o=1.
REQ-027 Push with fetch_fault_page_i=1, pc=0x8000_1006 -> out0 valid, fault_page=1, instr 0, pc 0x8000_1004; out1 invalid.
REQ-028 Continuous push and pop each cycle at occupancy 2 for 16 cycles -> occupancy stays 2, pointers wrap, output order matches input order.
